// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between the IF and LS ports in front of the scratch memory; one access in flight at a time.
// Grant is combinational in IDLE, mem strobe the next cycle, response pulse 2 cycles after grant (1 for misaligned LS).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [1:0]        ls_size_i,
  input  logic              ls_unsigned_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_valid_o,
  output logic              ls_err_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_write_o,
  output logic [1:0]        mem_write_size_o,
  output logic              mem_valid_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_valid_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            state_q;
  logic              last_ls_q;
  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [1:0]        mem_size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] ls_rdata_q;

  logic              gnt_ls, gnt_if, misalign;
  logic [1:0]        ls_size_enc;
  logic [DATA_W-1:0] lane, ld_ext;
  logic              unused_if_addr;

  assign unused_if_addr = ^if_addr_i[1:0];

  // last_q doubles as the owner of the access in flight
  always_comb begin
    gnt_ls = 1'b0;
    gnt_if = 1'b0;
    if (resetn_i && state_q == S_IDLE) begin
      if (ls_req_i && (!if_req_i || !last_ls_q)) gnt_ls = 1'b1;
      else if (if_req_i)                          gnt_if = 1'b1;
    end
  end

  always_comb begin
    misalign = 1'b0;
    case (ls_size_i)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = ls_addr_i[0];
      2'b10:   misalign = |ls_addr_i[1:0];
      default: misalign = 1'b1;
    endcase
  end

  assign ls_size_enc = (ls_size_i == 2'b10) ? 2'b11 : ls_size_i;

  always_comb begin
    lane   = mem_data_i >> {addr_q[1:0], 3'b000};
    ld_ext = mem_data_i;
    case (size_q)
      2'b00: ld_ext = uns_q ? {{(DATA_W-8){1'b0}}, lane[7:0]}
                            : {{(DATA_W-8){lane[7]}}, lane[7:0]};
      2'b01: ld_ext = uns_q ? {{(DATA_W-16){1'b0}}, lane[15:0]}
                            : {{(DATA_W-16){lane[15]}}, lane[15:0]};
      default: ld_ext = mem_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      last_ls_q  <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      mem_size_q <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_ls) begin
            last_ls_q  <= 1'b1;
            we_q       <= ls_we_i;
            uns_q      <= ls_unsigned_i;
            size_q     <= ls_size_i;
            mem_size_q <= ls_we_i ? ls_size_enc : 2'b00;
            addr_q     <= ls_addr_i;
            wdata_q    <= ls_wdata_i;
            err_q      <= misalign;
            state_q    <= misalign ? S_RESP : S_ACCESS;
          end else if (gnt_if) begin
            last_ls_q  <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b10;
            mem_size_q <= 2'b00;
            addr_q     <= {if_addr_i[ADDR_W-1:2], 2'b00};
            err_q      <= 1'b0;
            state_q    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_valid_i) begin
            if (!last_ls_q)  if_data_q  <= mem_data_i;
            else if (!we_q)  ls_rdata_q <= ld_ext;
            state_q <= S_RESP;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_gnt_o         = gnt_if;
  assign ls_gnt_o         = gnt_ls;
  assign if_valid_o       = (state_q == S_RESP) && !last_ls_q;
  assign ls_valid_o       = (state_q == S_RESP) && last_ls_q;
  assign ls_err_o         = ls_valid_o && err_q;
  assign if_data_o        = if_data_q;
  assign ls_rdata_o       = ls_rdata_q;
  assign mem_valid_o      = (state_q == S_ACCESS);
  assign mem_write_o      = (state_q == S_ACCESS) && we_q;
  assign mem_addr_o       = addr_q;
  assign mem_data_o       = wdata_q;
  assign mem_write_size_o = mem_size_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array memory, byte-level reference model, directed then random accesses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_valid_o;
  logic [31:0] if_data_o;
  logic        ls_req_i, ls_we_i, ls_unsigned_i;
  logic [1:0]  ls_size_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_valid_o, ls_err_o;
  logic [31:0] ls_rdata_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic        mem_write_o, mem_valid_o;
  logic [1:0]  mem_write_size_o;
  logic [31:0] mem_data_i;
  logic        mem_valid_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn_i(resetn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_valid_o(if_valid_o), .if_data_o(if_data_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
    .ls_unsigned_i(ls_unsigned_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_valid_o(ls_valid_o), .ls_err_o(ls_err_o),
    .ls_rdata_o(ls_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_write_o(mem_write_o),
    .mem_write_size_o(mem_write_size_o), .mem_valid_o(mem_valid_o),
    .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i)
  );

  // Memory seen by the DUT, and the bench's own expectation of its contents
  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];
  logic [1:0] wait_cnt = 2'd0;
  int         next_wait = 0;
  logic [5:0] wa;

  assign wa          = mem_addr_o[7:2];
  assign mem_data_i  = {mem[{wa, 2'b11}], mem[{wa, 2'b10}], mem[{wa, 2'b01}], mem[{wa, 2'b00}]};
  assign mem_valid_i = mem_valid_o && (wait_cnt == 2'd0);

  always @(posedge clk) begin
    if (!mem_valid_o)          wait_cnt <= next_wait[1:0];
    else if (wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
    if (mem_valid_o && mem_valid_i && mem_write_o) begin
      mem[mem_addr_o[7:0]] <= mem_data_o[7:0];
      if (mem_write_size_o != 2'b00) mem[mem_addr_o[7:0] + 8'd1] <= mem_data_o[15:8];
      if (mem_write_size_o == 2'b11) begin
        mem[mem_addr_o[7:0] + 8'd2] <= mem_data_o[23:16];
        mem[mem_addr_o[7:0] + 8'd3] <= mem_data_o[31:24];
      end
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_ls_rd = 32'h0;
  logic [31:0] exp_if_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [7:0] a);
    logic [31:0] v;
    case (size)
      2'd0: begin
        v = {24'h0, ref_mem[a]};
        if (!uns && v[7]) v = v | 32'hFFFFFF00;
      end
      2'd1: begin
        v = {16'h0, ref_mem[a + 8'd1], ref_mem[a]};
        if (!uns && v[15]) v = v | 32'hFFFF0000;
      end
      default: v = ref_word(a);
    endcase
    return v;
  endfunction

  task automatic set_word(input logic [7:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      mem[a + 8'(k)]     = w[8*k +: 8];
      ref_mem[a + 8'(k)] = w[8*k +: 8];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'h0, if_gnt_o, if_valid_o, ls_gnt_o, ls_valid_o, ls_err_o,
                        mem_write_o} | {30'h0, mem_write_size_o} | {31'h0, mem_valid_o}, 32'h0);
    chk({tag, "_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_wdat"}, mem_data_o, 32'h0);
    chk({tag, "_ifd"}, if_data_o, 32'h0);
    chk({tag, "_lsd"}, ls_rdata_o, 32'h0);
  endtask

  task automatic ls_txn(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic mis, got;
    int   lat;
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    if (!mis && !we) exp_ls_rd = model_load(size, uns, addr[7:0]);
    if (!mis && we) begin
      for (int k = 0; k < (size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4); k++)
        ref_mem[addr[7:0] + 8'(k)] = wdata[8*k +: 8];
    end
    @(posedge clk); #1;
    ls_req_i = 1'b1; ls_we_i = we; ls_size_i = size; ls_unsigned_i = uns;
    ls_addr_i = addr; ls_wdata_i = wdata;
    @(negedge clk); got = ls_gnt_o;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = ls_gnt_o; end
    chk("ls_gnt", {31'h0, got}, 32'h1);
    @(posedge clk); #1; ls_req_i = 1'b0;
    @(negedge clk); lat = 1;
    if (mis) chk("ls_mis_nomem", {31'h0, mem_valid_o}, 32'h0);
    else begin
      chk("ls_mem_vld", {31'h0, mem_valid_o}, 32'h1);
      chk("ls_mem_addr", mem_addr_o, addr);
      chk("ls_mem_we", {31'h0, mem_write_o}, {31'h0, we});
      chk("ls_mem_size", {30'h0, mem_write_size_o},
          we ? ((size == 2'd2) ? 32'd3 : {30'h0, size}) : 32'd0);
      if (we) chk("ls_mem_wdat", mem_data_o, wdata);
    end
    got = ls_valid_o;
    while (!got && lat < 20) begin @(negedge clk); lat++; got = ls_valid_o; end
    chk("ls_lat", lat, mis ? 32'd1 : 32'(2 + next_wait));
    chk("ls_err", {31'h0, ls_err_o}, {31'h0, mis});
    chk("ls_rdata", ls_rdata_o, exp_ls_rd);
  endtask

  task automatic if_txn(input logic [31:0] addr);
    logic got;
    int   lat;
    exp_if_rd = ref_word(addr[7:0]);
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = addr;
    @(negedge clk); got = if_gnt_o;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = if_gnt_o; end
    chk("if_gnt", {31'h0, got}, 32'h1);
    @(posedge clk); #1; if_req_i = 1'b0;
    @(negedge clk); lat = 1;
    chk("if_mem_vld", {31'h0, mem_valid_o}, 32'h1);
    chk("if_mem_addr", mem_addr_o, {addr[31:2], 2'b00});
    chk("if_mem_ctl", {29'h0, mem_write_o, mem_write_size_o}, 32'h0);
    got = if_valid_o;
    while (!got && lat < 20) begin @(negedge clk); lat++; got = if_valid_o; end
    chk("if_lat", lat, 32'(2 + next_wait));
    chk("if_data", if_data_o, exp_if_rd);
  endtask

  initial begin
    logic [31:0] order [4];
    int          ng, nv;
    for (int k = 0; k < 256; k++) begin
      mem[k]     = 8'($urandom);
      ref_mem[k] = mem[k];
    end
    set_word(8'h00, 32'h7c7fe2b7);
    set_word(8'h04, 32'h00218193);
    resetn_i = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_size_i = 2'd0; ls_unsigned_i = 1'b0;
    ls_addr_i = 32'h0; ls_wdata_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1; resetn_i = 1'b1;

    // Both ports held: round robin starting with LS after reset
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = 32'h0;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'd2; ls_addr_i = 32'h4;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (ls_gnt_o && if_gnt_o) chk("rr_both", 32'h1, 32'h0);
      if (ls_gnt_o) begin order[ng] = 32'h1; ng++; end
      else if (if_gnt_o) begin order[ng] = 32'h0; ng++; end
    end
    @(posedge clk); #1; if_req_i = 1'b0; ls_req_i = 1'b0;
    chk("rr_count", ng, 32'd4);
    chk("rr_0", order[0], 32'h1);
    chk("rr_1", order[1], 32'h0);
    chk("rr_2", order[2], 32'h1);
    chk("rr_3", order[3], 32'h0);
    repeat (3) @(negedge clk);
    exp_ls_rd = 32'h00218193;
    chk("rr_lsd", ls_rdata_o, exp_ls_rd);

    next_wait = 0;
    if_txn(32'h0);
    chk("if_word0", if_data_o, 32'h7c7fe2b7);
    ls_txn(1'b0, 2'd0, 1'b0, 32'h5, 32'h0);
    chk("lb_sext", ls_rdata_o, 32'hFFFFFF81);
    ls_txn(1'b0, 2'd0, 1'b1, 32'h5, 32'h0);
    chk("lbu_zext", ls_rdata_o, 32'h00000081);
    ls_txn(1'b1, 2'd1, 1'b0, 32'h2, 32'h0000BEEF);
    ls_txn(1'b0, 2'd1, 1'b1, 32'h2, 32'h0);
    chk("lhu_beef", ls_rdata_o, 32'h0000BEEF);
    ls_txn(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);

    // Reset while the memory is still stalling
    next_wait = 3;
    @(posedge clk); #1; if_req_i = 1'b1; if_addr_i = 32'h10;
    @(negedge clk); chk("rst_gnt", {31'h0, if_gnt_o}, 32'h1);
    @(posedge clk); #1; if_req_i = 1'b0;
    @(negedge clk); chk("rst_in_acc", {31'h0, mem_valid_o}, 32'h1);
    @(posedge clk); #1; resetn_i = 1'b0;
    @(posedge clk); #1; resetn_i = 1'b1;
    @(negedge clk); chk_all_zero("midrst");
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if_valid_o || ls_valid_o) nv++;
    end
    chk("midrst_novld", nv, 32'd0);
    exp_ls_rd = 32'h0;
    next_wait = 0;
    if_txn(32'h14);

    for (int n = 0; n < 60; n++) begin
      next_wait = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) if_txn(32'($urandom_range(0, 255)));
      else ls_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
